// File: rtl/prod_pkg.sv
// Shared types and widths for the product accumulator.
package prod_pkg;

  localparam int unsigned SUM_W  = 12;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] count;
  } acc_t;

endpackage

// File: rtl/prod_accum.sv
// Accumulates a group of 8-bit products into a 12-bit sum and holds the
// result with a valid/ready handshake until downstream takes it.
module prod_accum
  import prod_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
);

  state_t state_q, state_d;
  acc_t   acc_q, acc_d;
  logic   in_ready_d;
  logic   out_valid_d;
  logic   accept;

  // State, accumulator and handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  assign accept = in_valid && in_ready;

  // Next-state and accumulator update; clr overrides everything
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d.sum   = SUM_W'(in_prod);
          acc_d.count = CNT_W'(1);
          state_d     = (in_last || (acc_d.count == CNT_W'(MAX_TERMS))) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d.sum   = acc_q.sum + SUM_W'(in_prod);
          acc_d.count = acc_q.count + CNT_W'(1);
          if (in_last || (acc_d.count == CNT_W'(MAX_TERMS))) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
    end
    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  assign out_sum   = acc_q.sum;
  assign out_count = acc_q.count;

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: default instance plus a MAX_TERMS=1 instance.
module tb_prod_accum;
  import prod_pkg::*;

  logic              clk = 1'b0;
  logic              rst, clr;
  logic              in_valid, in_last, out_ready;
  logic              in_valid1, out_ready1;
  logic [PROD_W-1:0] in_prod;
  logic              in_ready, out_valid, in_ready1, out_valid1;
  logic [SUM_W-1:0]  out_sum, out_sum1;
  logic [CNT_W-1:0]  out_count, out_count1;

  acc_t sb[$];
  acc_t exp_r;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  prod_accum #(.MAX_TERMS(16)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
  );

  prod_accum #(.MAX_TERMS(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1), .out_count(out_count1)
  );

  // Drive one beat from a negedge; returns at the negedge after it was accepted
  task automatic send(input logic [PROD_W-1:0] p, input logic l);
    int n;
    in_valid = 1'b1; in_prod = p; in_last = l;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    ok = (out_valid === 1'b1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    tests++; if (out_sum !== 12'd0) begin fails++; $display("FAIL rst_sum: got %0d required 0", out_sum); end
    tests++; if (out_count !== 5'd0) begin fails++; $display("FAIL rst_count: got %0d required 0", out_count); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic();
    sb.push_back('{sum: 12'd60, count: 5'd3});
    send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: out_valid=%b required 1", out_valid); end
    exp_r = sb.pop_front();
    tests++; if (out_sum !== exp_r.sum) begin fails++; $display("FAIL basic_sum: got %0d required %0d", out_sum, exp_r.sum); end
    tests++; if (out_count !== exp_r.count) begin fails++; $display("FAIL basic_count: got %0d required %0d", out_count, exp_r.count); end
    take();
  endtask

  task automatic test_max_terms();
    sb.push_back('{sum: 12'd3600, count: 5'd16});
    for (int i = 0; i < 15; i++) send(8'd225, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL max_early: out_valid=%b required 0", out_valid); end
    send(8'd225, 1'b0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL max_latency: out_valid=%b required 1", out_valid); end
    exp_r = sb.pop_front();
    tests++; if (out_sum !== exp_r.sum) begin fails++; $display("FAIL max_sum: got %0d required %0d", out_sum, exp_r.sum); end
    tests++; if (out_count !== exp_r.count) begin fails++; $display("FAIL max_count: got %0d required %0d", out_count, exp_r.count); end
    take();
  endtask

  task automatic test_backpressure();
    bit ok;
    sb.push_back('{sum: 12'd3, count: 5'd2});
    sb.push_back('{sum: 12'd9, count: 5'd1});
    send(8'd1, 1'b0); send(8'd2, 1'b1);
    exp_r = sb.pop_front();
    in_valid = 1'b1; in_prod = 8'd9; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== exp_r.sum || out_count !== exp_r.count) begin
        fails++;
        $display("FAIL hold_stable[%0d]: valid=%b ready=%b sum=%0d count=%0d required 1 0 %0d %0d",
                 i, out_valid, in_ready, out_sum, out_count, exp_r.sum, exp_r.count);
      end
      @(negedge clk);
    end
    take();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 12'd0) begin
      fails++;
      $display("FAIL hold_release: valid=%b ready=%b sum=%0d required 0 1 0", out_valid, in_ready, out_sum);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    wait_valid(ok);
    exp_r = sb.pop_front();
    tests++; if (!ok || out_sum !== exp_r.sum) begin fails++; $display("FAIL after_hold_sum: got %0d required %0d", out_sum, exp_r.sum); end
    tests++; if (out_count !== exp_r.count) begin fails++; $display("FAIL after_hold_count: got %0d required %0d", out_count, exp_r.count); end
    take();
  endtask

  task automatic test_clr();
    bit ok;
    send(8'd40, 1'b0);
    in_valid = 1'b1; in_prod = 8'd50; clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_sum !== 12'd0 || out_count !== 5'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL clr_state: valid=%b sum=%0d count=%0d ready=%b required 0 0 0 1", out_valid, out_sum, out_count, in_ready);
    end
    sb.push_back('{sum: 12'd7, count: 5'd1});
    send(8'd7, 1'b1);
    wait_valid(ok);
    exp_r = sb.pop_front();
    tests++; if (!ok || out_sum !== exp_r.sum) begin fails++; $display("FAIL clr_next_sum: got %0d required %0d", out_sum, exp_r.sum); end
    tests++; if (out_count !== exp_r.count) begin fails++; $display("FAIL clr_next_count: got %0d required %0d", out_count, exp_r.count); end
    take();
  endtask

  task automatic test_async_rst();
    bit ok;
    send(8'd8, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_sum !== 12'd0 || out_count !== 5'd0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_rst: sum=%0d count=%0d ready=%b valid=%b required all 0", out_sum, out_count, in_ready, out_valid);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL async_rst_ready: got %b required 1", in_ready); end
    sb.push_back('{sum: 12'd11, count: 5'd2});
    send(8'd5, 1'b0); send(8'd6, 1'b1);
    wait_valid(ok);
    exp_r = sb.pop_front();
    tests++; if (!ok || out_sum !== exp_r.sum) begin fails++; $display("FAIL async_next_sum: got %0d required %0d", out_sum, exp_r.sum); end
    tests++; if (out_count !== exp_r.count) begin fails++; $display("FAIL async_next_count: got %0d required %0d", out_count, exp_r.count); end
    take();
  endtask

  task automatic test_gap();
    bit ok;
    sb.push_back('{sum: 12'd7, count: 5'd2});
    send(8'd3, 1'b0);
    repeat (4) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_count !== 5'd1 || out_sum !== 12'd3) begin
      fails++;
      $display("FAIL gap_state: valid=%b count=%0d sum=%0d required 0 1 3", out_valid, out_count, out_sum);
    end
    send(8'd4, 1'b1);
    wait_valid(ok);
    exp_r = sb.pop_front();
    tests++; if (!ok || out_sum !== exp_r.sum) begin fails++; $display("FAIL gap_sum: got %0d required %0d", out_sum, exp_r.sum); end
    tests++; if (out_count !== exp_r.count) begin fails++; $display("FAIL gap_count: got %0d required %0d", out_count, exp_r.count); end
    take();
  endtask

  task automatic test_single_term();
    logic [PROD_W-1:0] vals [2];
    vals[0] = 8'd3; vals[1] = 8'd4;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{sum: SUM_W'(vals[i]), count: 5'd1});
      tests++; if (in_ready1 !== 1'b1) begin fails++; $display("FAIL one_ready[%0d]: got %b required 1", i, in_ready1); end
      in_valid1 = 1'b1; in_prod = vals[i]; in_last = 1'b0;
      @(negedge clk);
      in_valid1 = 1'b0;
      exp_r = sb.pop_front();
      tests++; if (out_valid1 !== 1'b1) begin fails++; $display("FAIL one_valid[%0d]: got %b required 1", i, out_valid1); end
      tests++; if (out_sum1 !== exp_r.sum) begin fails++; $display("FAIL one_sum[%0d]: got %0d required %0d", i, out_sum1, exp_r.sum); end
      tests++; if (out_count1 !== exp_r.count) begin fails++; $display("FAIL one_count[%0d]: got %0d required %0d", i, out_count1, exp_r.count); end
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_prod = '0;
    out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    test_reset();
    test_basic();
    test_max_terms();
    test_backpressure();
    test_clr();
    test_async_rst();
    test_gap();
    test_single_term();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 SHALL have parameter MAX_TERMS, default 16, giving the maximum products per accumulation group (legal range 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clr  input  1  synchronous abort of the current group.
REQ-005 SHALL have port in_valid  input  1  upstream product beat valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a product beat.
REQ-007 SHALL have port in_prod  input  8  unsigned product from the 4x4 multiplier stage (0..225).
REQ-008 SHALL have port in_last  input  1  marks the final beat of a group.
REQ-009 SHALL have port out_valid  output  1  group result available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_sum  output  12  unsigned sum of the group's products.
REQ-012 SHALL have port out_count  output  5  number of products in the group (1..16).

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-014 SHALL define a beat accept as in_valid && in_ready on a rising clk edge.
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in HOLD.
REQ-016 On accept in IDLE: sum <= in_prod, count <= 1, next state ACCUM.
REQ-017 On accept in ACCUM: sum <= sum + in_prod, count <= count + 1.
REQ-018 SHALL enter HOLD on the accept carrying in_last=1, or on the accept that makes count equal MAX_TERMS, whichever comes first.
REQ-019 SHALL compute the sum as full-width 12-bit unsigned arithmetic; 16 x 225 = 3600 fits, so no saturation or wrap logic is needed.
REQ-020 SHALL assert out_valid only in HOLD, one cycle after the terminating accept (latency 1).
REQ-021 SHALL hold out_sum and out_count stable while out_valid=1 && out_ready=0.
REQ-022 On out_valid && out_ready: next state IDLE, with sum and count cleared to 0.
REQ-023 SHALL NOT accept a beat in the cycle the result is taken; the next group starts no earlier than the following cycle.
REQ-024 clr=1 SHALL force IDLE with sum=0 and count=0 from any state.
REQ-025 clr SHALL take priority over a simultaneous accept (the beat is dropped) and over a simultaneous result handshake.
REQ-026 With MAX_TERMS=1, every accept SHALL terminate its group.
REQ-027 An in_last=1 beat SHALL be treated identically whether it arrives in IDLE or in ACCUM.
REQ-028 in_valid=0 in ACCUM SHALL leave all state unchanged; gaps between beats are unbounded.

Reset
REQ-029 While rst=1: state=IDLE, sum=0, count=0, out_valid=0, in_ready=0, asynchronously.
REQ-030 After rst deasserts: in_ready=1 from the first clk edge.
REQ-031 rst asserted mid-group or in HOLD SHALL discard the partial or pending result.

Structure
REQ-032 SHALL place the FSM state encoding, SUM_W=12, CNT_W=5 and PROD_W=8 in the shared package prod_pkg.
REQ-033 SHALL be a single module with no sub-modules; the 4x4 multiplier stays external and upstream.
REQ-034 SHALL register out_sum and out_count directly from the accumulator registers, with no combinational path from in_* to out_*.

Verification
REQ-035 Products 10, 20, 30, with in_last on 30, sent back-to-back -> out_valid 1 cycle later with out_sum=60 and out_count=3.
REQ-036 16 beats of 225, no in_last -> termination on the 16th beat with out_sum=3600 and out_count=16.
REQ-037 Result pending with out_ready=0 for 5 cycles -> out_valid and outputs stable and in_ready=0; when out_ready rises, IDLE next cycle and the next beat is accepted.
REQ-038 clr asserted together with an accepted beat of 50 after sum=40 -> state IDLE, sum=0, no out_valid; the next group of 7 (last) gives out_sum=7.
REQ-039 rst pulsed asynchronously mid-group (between clk edges) -> outputs 0 immediately; the next group of 5, 6 (last) gives out_sum=11 and out_count=2.
REQ-040 MAX_TERMS=1, beats 3 and 4 -> two results: 3 with count 1, then 4 with count 1.
